// File: rtl/ps2_send_pkg.sv
// ps2_send_pkg: shared types and 25 MHz timing defaults for the PS/2 host
// transmitter.
package ps2_send_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    DATA,
    STOP,
    ACK
  } state_t;

  // 100 us clock-low inhibit at 25 MHz
  localparam int INHIBIT_CYC_25M = 2500;
  // 15 ms from clock release to end of ACK at 25 MHz
  localparam int TIMEOUT_CYC_25M = 375000;
  // consecutive equal samples before a new clock level is accepted
  localparam int FILTER_LEN_DEF  = 4;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: 2-flop synchronizer, FILTER_LEN glitch filter and
// one-cycle falling-edge pulse for an asynchronous PS/2 clock line.
module ps2_clk_filter
  import ps2_send_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer; resets to the idle-high line level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], line_i};
  end

  // Accept a new level only after FILTER_LEN samples that disagree with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_send.sv
// ps2_send: PS/2 host-to-device transmitter (write side of the keyboard
// link). Pins are driven open-drain through ps2_clk_oe / ps2_dat_oe.
// Build option: define PS2SEND_ACK_CHECK_EN to turn a missing device ACK
// into tx_error; otherwise the ACK-clock fall always completes with tx_done.
//
// state   | meaning
// IDLE    | lines released, waiting for tx_start
// INHIBIT | clock held low, start bit asserted just before release
// DATA    | 8 data bits then parity, one per device clock fall
// STOP    | next fall releases data (stop bit = 1)
// ACK     | next fall samples the device ACK bit
module ps2_send
  import ps2_send_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_CYC_25M,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_25M,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

`ifdef PS2SEND_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [8:0]    shift;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    dat_sync;
  logic          clk_level;
  logic          clk_fall_raw;
  logic          clk_fall;
  logic          timeout_hit;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock (clock),
    .reset (reset),
    .line_i(ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall_raw)
  );

  // A fall is honoured only while the filtered level still reads low
  assign clk_fall    = clk_fall_raw & ~clk_level;
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));

  // Data line synchronizer used for the ACK sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) dat_sync <= 2'b11;
    else       dat_sync <= {dat_sync[0], ps2_dat_i};
  end

  // Transfer sequencer with registered pin enables and status pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          // a start coinciding with a completion pulse is dropped
          if (tx_start && !tx_done && !tx_error) begin
            shift      <= {odd_parity(tx_data), tx_data};
            inh_cnt    <= '0;
            bit_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          // registered enables: decisions one count early so the clock is
          // held low for exactly INHIBIT_CYC cycles
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == IW'(INHIBIT_CYC - 2)) ps2_dat_oe <= 1'b1;
          if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            state      <= DATA;
          end
        end
        DATA, STOP, ACK: begin
          to_cnt <= to_cnt + 1'b1;
          if (timeout_hit) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_busy    <= 1'b0;
            tx_error   <= 1'b1;
            state      <= IDLE;
          end else if (clk_fall) begin
            case (state)
              DATA: begin
                ps2_dat_oe <= ~shift[0];
                shift      <= {1'b0, shift[8:1]};
                if (bit_cnt == 4'd8) state <= STOP;
                else                 bit_cnt <= bit_cnt + 1'b1;
              end
              STOP: begin
                ps2_dat_oe <= 1'b0;
                state      <= ACK;
              end
              default: begin
                tx_busy <= 1'b0;
                if (ACK_CHECK && dat_sync[1]) tx_error <= 1'b1;
                else                          tx_done  <= 1'b1;
                state <= IDLE;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_send.sv
// tb_ps2_send: directed bench for ps2_send with a simple PS/2 device model
// (open-drain pins, 15-cycle clock half periods).
module tb_ps2_send;

`ifdef PS2SEND_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       dev_clk, dev_dat;
  logic       ps2_clk_i, ps2_dat_i;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0;

  always #5 clock = ~clock;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_send #(
    .INHIBIT_CYC(2500),
    .TIMEOUT_CYC(1000),
    .FILTER_LEN (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always @(negedge clock) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // returns the number of cycles the clock enable stayed high; ends on the
  // first cycle after release
  task automatic wait_release(output int k);
    k = 0;
    while (ps2_clk_oe && k < 5000) begin
      k++;
      @(negedge clock);
    end
  endtask

  task automatic dev_xfer(input logic [7:0] d, input logic ack_lvl, input bit glitch);
    int k, d0, e0;
    logic [9:0] frame;
    logic exp_err;
    exp_err = ACK_CHECK && ack_lvl;
    d0 = done_cnt;
    e0 = err_cnt;
    frame = '0;
    pulse_start(d);
    check_eq("busy_start", tx_busy, 1);
    wait_release(k);
    check_eq("inhibit_len", k, 2500);
    check_eq("start_bit", ps2_dat_oe, 1);
    repeat (10) @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_dat = ack_lvl;
      @(negedge clock);
      dev_clk = 1'b0;
      for (int j = 0; j < 15; j++) begin
        @(negedge clock);
        if (tx_done || tx_error) begin
          check_eq("busy_at_pulse", tx_busy, 0);
          tx_data  = ~d;
          tx_start = 1'b1;
        end else begin
          tx_start = 1'b0;
        end
      end
      tx_start = 1'b0;
      if (i < 10) frame[i] = ps2_dat_i;
      dev_clk = 1'b1;
      if (glitch && i == 3) begin
        repeat (6) @(negedge clock);
        dev_clk = 1'b0;
        repeat (2) @(negedge clock);
        dev_clk = 1'b1;
        repeat (7) @(negedge clock);
      end else if (i == 1) begin
        repeat (7) @(negedge clock);
        tx_data  = ~d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (7) @(negedge clock);
      end else begin
        repeat (15) @(negedge clock);
      end
    end
    dev_dat = 1'b1;
    repeat (5) @(negedge clock);
    check_eq("frame", frame, {1'b1, ~^d, d});
    check_eq("done_cnt", done_cnt - d0, !exp_err);
    check_eq("err_cnt", err_cnt - e0, exp_err);
    check_eq("busy_end", tx_busy, 0);
    check_eq("oe_end", {ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin
    int k, d0, e0;
    reset    = 1'b1;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check_eq("reset_outs", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    dev_xfer(8'hED, 1'b0, 1'b0);
    dev_xfer(8'h02, 1'b0, 1'b0);
    dev_xfer(8'h00, 1'b0, 1'b0);
    dev_xfer(8'h5A, 1'b1, 1'b0);
    dev_xfer(8'hC3, 1'b0, 1'b1);

    // device never clocks
    pulse_start(8'h55);
    wait_release(k);
    check_eq("to_inhibit_len", k, 2500);
    k = 0;
    while (!tx_error && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check_eq("timeout_cyc", k, 1000);
    check_eq("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check_eq("timeout_busy", tx_busy, 0);
    repeat (5) @(negedge clock);

    // reset after the 4th data bit of 0x30 (bit 3 = 0 -> data pulled low)
    pulse_start(8'h30);
    wait_release(k);
    repeat (10) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (15) @(negedge clock);
      dev_clk = 1'b1;
      repeat (15) @(negedge clock);
    end
    check_eq("mid_dat_oe", ps2_dat_oe, 1);
    check_eq("mid_busy", tx_busy, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check_eq("rst_busy", tx_busy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_eq("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);

    dev_xfer(8'hFF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_send.md
Name: ps2_send

Overview:
- PS/2 host-to-device transmitter; the write direction of the PS/2 keyboard link, complementing the existing keyboard receiver.
- Sends command bytes to the keyboard: 0xED LED set, 0xFF reset, 0xF3 typematic.
- Driven from the port controller in the clock_25 domain.
- Drives PS2_CLK/PS2_DAT open-drain via output-enable lines; the board top forms the tri-state.

Parameters:
- INHIBIT_CYC, 2500: clock-low inhibit time in clock cycles (100 us at 25 MHz).
- TIMEOUT_CYC, 375000: max cycles from clock release to end of ACK (15 ms at 25 MHz).
- FILTER_LEN, 4: consecutive equal samples required to accept a new ps2_clk_i level.

Ports:
- clock      input   1   system clock (clock_25)
- reset      input   1   asynchronous, active-high reset
- ps2_clk_i  input   1   PS2_CLK pin level (asynchronous)
- ps2_dat_i  input   1   PS2_DAT pin level (asynchronous)
- ps2_clk_oe output  1   1 = drive PS2_CLK low; 0 = release (Z)
- ps2_dat_oe output  1   1 = drive PS2_DAT low; 0 = release (Z)
- tx_data    input   8   byte to send, captured on tx_start
- tx_start   input   1   one-cycle start request
- tx_busy    output  1   transfer in progress
- tx_done    output  1   one-cycle pulse: byte sent and acknowledged
- tx_error   output  1   one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (async):
  - all outputs 0.
  - State IDLE; shift register 0; counters 0.
  - Filtered clock level 1.
- Input conditioning:
  - ps2_clk_i and ps2_dat_i pass through 2-flop synchronizers.
  - The clock level updates only after FILTER_LEN equal samples.
  - fall = filtered level 1 -> 0, asserted for one cycle.
- IDLE:
  - oe outputs 0; tx_busy 0.
  - tx_start latches {parity, tx_data}; parity = ~^tx_data (odd).
  - Next state INHIBIT; tx_busy = 1 from the following cycle.
- INHIBIT:
  - ps2_clk_oe = 1.
  - At INHIBIT_CYC-1, assert ps2_dat_oe = 1 (start bit).
  - At INHIBIT_CYC, release ps2_clk_oe, clear the timeout counter, go to DATA.
- DATA:
  - On each fall: ps2_dat_oe = ~shift[0]; shift right.
  - Bit counter 0..8 covers 8 data bits (LSB first) then parity.
  - After the 9th fall (parity driven), go to STOP.
- STOP:
  - On the next fall, release ps2_dat_oe (stop bit = 1); go to ACK.
- ACK:
  - On the next fall, sample the synchronized data line.
  - 0 = ACK: tx_done pulse, go to IDLE.
  - 1 = no ACK: see Optional Feature.
- Timeout:
  - Counter runs in DATA/STOP/ACK.
  - Reaching TIMEOUT_CYC releases both oe outputs, pulses tx_error, returns to IDLE.
- tx_start while tx_busy=1 is ignored; tx_data is not re-captured.
- tx_start in the same cycle a done/error pulse is issued is ignored; the initiator waits for tx_busy=0.
- Falls arriving in IDLE or INHIBIT are ignored.
- tx_busy drops in the same cycle as the done/error pulse.
- Reset mid-transfer releases both lines immediately; no pulse is issued.
- Never drives a pin high.

Optional Feature:
- Macro: PS2SEND_ACK_CHECK_EN.
- Defined: an ACK-bit sample of 1 pulses tx_error instead of tx_done.
- Undefined: the ACK sample is ignored; the ACK-clock fall always pulses tx_done. Timeout errors remain.

Decomposition:
- Shared package holds:
  - state enum: IDLE, INHIBIT, DATA, STOP, ACK.
  - default cycle constants for 25 MHz: INHIBIT 2500, TIMEOUT 375000.
- One sub-module, ps2_clk_filter: synchronizer, FILTER_LEN glitch filter, fall-edge pulse. The future PS/2 receiver rewrite reuses it.

Test Plan:
- Send 0xED with device model, ACK=0:
  - ps2_clk_oe low 2500 cycles.
  - Bits driven 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Single tx_done; tx_busy 1->0.
- Send 0x02: parity bit 0; send 0x00: parity bit 1.
  - Line levels checked at each device clock fall.
- Device never clocks, TIMEOUT_CYC=1000 in sim:
  - tx_error exactly 1000 cycles after clock release.
  - Both oe = 0.
- Device holds data high during ACK clock:
  - With PS2SEND_ACK_CHECK_EN: tx_error.
  - Without: tx_done.
- 2-cycle glitch low on ps2_clk_i during DATA: no bit advance; byte still received correctly.
- Reset asserted after 4th data bit, plus tx_start pulsed while busy:
  - Reset releases oe lines asynchronously; tx_busy 0.
  - A later tx_start of 0xFF completes with the correct value.
  - Start while busy did not alter the byte.
